// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
//   - Requester ID constants for cpu_ooo's fixed requesters.
//   - ID_W: width of a requester ID, sized for the largest supported NREQ.
//   - ret_entry_t: one return-pipeline stage {valid, id, tag, we}.
//   - rr_next: round-robin increment with wrap.
package mem_arb_pkg;

  localparam int unsigned REQ_FETCH = 0;
  localparam int unsigned REQ_LOAD  = 1;
  localparam int unsigned REQ_STORE = 2;

  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned ID_W     = $clog2(MAX_NREQ);

  // Tag field is sized for the widest supported requester tag; narrower tags are zero-extended.
  localparam int unsigned MAX_TAGW = 16;

  typedef struct packed {
    logic                valid;
    logic [ID_W-1:0]     id;
    logic [MAX_TAGW-1:0] tag;
    logic                we;
  } ret_entry_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 == n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/mem_ret_pipe.sv
// Return pipeline for one memory port: a Depth-stage shift register of ret_entry_t.
//   clk, rst   : clock, asynchronous active-high reset (clears every stage)
//   in_entry   : entry captured into stage 0 at each clock edge
//   out_entry  : last stage; its valid bit marks a response due this cycle
module mem_ret_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  ret_entry_t in_entry,
  output ret_entry_t out_entry
);

  ret_entry_t stage_q [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= in_entry;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_entry = stage_q[Depth-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin memory arbiter for cpu_ooo.
//   req_*            : per-requester request (valid/we/addr/wdata/tag), packed i*W +: W
//   req_ready        : grant this cycle; transfer on req_valid & req_ready
//   resp_*           : per-requester response pulse, read data (0 for writes), echoed tag
//   addr1/2, data_out1/2, we1/2 : memory port drive, combinational from the grant
//   data_in1/2       : memory read data, valid READ_LAT cycles after issue
// TAGW must not exceed mem_arb_pkg::MAX_TAGW.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 8,
  parameter int unsigned TAGW     = 4,
  parameter int unsigned READ_LAT = 1
) (
  input  logic [NREQ-1:0]      req_valid,
  input  logic                 clk,
  input  logic                 rst,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [NREQ-1:0]      resp_valid,
  output logic [NREQ*DW-1:0]   resp_data,
  output logic [NREQ*TAGW-1:0] resp_tag,
  output logic [AW-1:0]        addr1,
  output logic [AW-1:0]        addr2,
  output logic [DW-1:0]        data_out1,
  output logic [DW-1:0]        data_out2,
  output logic                 we1,
  output logic                 we2,
  input  logic [DW-1:0]        data_in1,
  input  logic [DW-1:0]        data_in2
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [AW-1:0]   addr_a  [NREQ];
  logic [DW-1:0]   wdata_a [NREQ];
  logic [TAGW-1:0] tag_a   [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*AW +: AW];
    assign wdata_a[i] = req_wdata[i*DW +: DW];
    assign tag_a[i]   = req_tag[i*TAGW +: TAGW];
  end

  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic            g1_vld, g2_vld;
  logic [PtrW-1:0] g1_idx, g2_idx;

  // Scan requesters starting at rr_ptr; first hit takes port 1, second takes port 2.
  // Visiting each index once guarantees a requester gets at most one port.
  always_comb begin
    logic [PtrW-1:0] cand;
    cand   = '0;
    g1_vld = 1'b0;
    g1_idx = '0;
    g2_vld = 1'b0;
    g2_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PtrW'((32'(rr_ptr_q) + k) % NREQ);
      if (!rst && req_valid[cand]) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = cand;
        end else if (!g2_vld) begin
          g2_vld = 1'b1;
          g2_idx = cand;
        end
      end
    end
    // Same address with a write on either side: port 2 backs off so the order stays defined.
    if (g1_vld && g2_vld && (addr_a[g1_idx] == addr_a[g2_idx]) &&
        (req_we[g1_idx] || req_we[g2_idx])) begin
      g2_vld = 1'b0;
      g2_idx = '0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (g1_vld) req_ready[g1_idx] = 1'b1;
    if (g2_vld) req_ready[g2_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (g2_vld) begin
      rr_ptr_d = PtrW'(rr_next(32'(g2_idx), NREQ));
    end else if (g1_vld) begin
      rr_ptr_d = PtrW'(rr_next(32'(g1_idx), NREQ));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign addr1     = g1_vld ? addr_a[g1_idx]  : '0;
  assign data_out1 = g1_vld ? wdata_a[g1_idx] : '0;
  assign we1       = g1_vld & req_we[g1_idx];
  assign addr2     = g2_vld ? addr_a[g2_idx]  : '0;
  assign data_out2 = g2_vld ? wdata_a[g2_idx] : '0;
  assign we2       = g2_vld & req_we[g2_idx];

  ret_entry_t ent1_in, ent2_in, ret1, ret2;

  always_comb begin
    ent1_in = '0;
    ent2_in = '0;
    if (g1_vld) begin
      ent1_in.valid = 1'b1;
      ent1_in.id    = ID_W'(g1_idx);
      ent1_in.tag   = MAX_TAGW'(tag_a[g1_idx]);
      ent1_in.we    = req_we[g1_idx];
    end
    if (g2_vld) begin
      ent2_in.valid = 1'b1;
      ent2_in.id    = ID_W'(g2_idx);
      ent2_in.tag   = MAX_TAGW'(tag_a[g2_idx]);
      ent2_in.we    = req_we[g2_idx];
    end
  end

  mem_ret_pipe #(
    .Depth (READ_LAT)
  ) u_ret1 (
    .clk       (clk),
    .rst       (rst),
    .in_entry  (ent1_in),
    .out_entry (ret1)
  );

  mem_ret_pipe #(
    .Depth (READ_LAT)
  ) u_ret2 (
    .clk       (clk),
    .rst       (rst),
    .in_entry  (ent2_in),
    .out_entry (ret2)
  );

  // The two ports never return to the same requester, so hit1/hit2 are mutually exclusive.
  for (genvar i = 0; i < NREQ; i++) begin : g_resp
    logic hit1, hit2;
    assign hit1 = ret1.valid && (ret1.id == ID_W'(i));
    assign hit2 = ret2.valid && (ret2.id == ID_W'(i));
    assign resp_valid[i] = hit1 | hit2;
    assign resp_data[i*DW +: DW] = (hit1 && !ret1.we) ? data_in1 :
                                   (hit2 && !ret2.we) ? data_in2 : '0;
    assign resp_tag[i*TAGW +: TAGW] = hit1 ? ret1.tag[TAGW-1:0] :
                                      hit2 ? ret2.tag[TAGW-1:0] : '0;
  end

  if (TAGW < MAX_TAGW) begin : g_tag_pad
    logic unused_tag_pad;
    assign unused_tag_pad = ^{ret1.tag[MAX_TAGW-1:TAGW], ret2.tag[MAX_TAGW-1:TAGW]};
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's two memory ports (port 1, port 2) among NREQ requesters (fetch, load, store, ...) of cpu_ooo.
- Grants up to two requests per cycle, round-robin, and drives the port address, data and write enable.
- Tracks each issued access through a READ_LAT-deep return pipeline and routes the response back to its requester with the request tag.
- Sits between cpu_ooo and core's addr1/addr2, data_in*, data_out*, we* pins.

Parameters:
- NREQ, 3, number of requesters (2..8)
- AW, 16, address width
- DW, 8, data width
- TAGW, 4, requester-supplied tag width
- READ_LAT, 1, cycles from address issue to valid data_in (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  request pending, per requester
- req_ready  out  NREQ  request accepted this cycle
- req_we  in  NREQ  1=write, 0=read
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- req_tag  in  NREQ*TAGW  packed tags
- resp_valid  out  NREQ  response pulse, per requester
- resp_data  out  NREQ*DW  packed read data (0 for writes)
- resp_tag  out  NREQ*TAGW  packed tag echoed from request
- addr1, addr2  out  AW  memory port addresses
- data_out1, data_out2  out  DW  memory write data
- we1, we2  out  1  memory write enables
- data_in1, data_in2  in  DW  memory read data, valid READ_LAT cycles after issue

Behaviour:
- Reset (async assert, sync release) drives the following to 0 and holds them there while rst=1:
  - rr_ptr
  - all return-pipeline valid bits
  - resp_valid, req_ready
  - we1, we2, addr1, addr2, data_out1, data_out2
- In-flight accesses are discarded on reset; no response is issued for them.
- Grant logic is combinational in the request cycle:
  - Port 1 goes to the first valid requester at or after rr_ptr, modulo NREQ.
  - Port 2 goes to the next valid requester after that one.
  - A requester receives at most one port per cycle.
- req_ready[i]=1 exactly when requester i is granted. The transfer occurs when req_valid & req_ready; no backpressure on the request side beyond this.
- Address hazard rule: if both candidate grants have equal addresses and at least one is a write, only port 1 issues. The second candidate gets req_ready=0 and retries next cycle.
- rr_ptr update on any cycle with at least one grant: (index of last granted requester + 1) mod NREQ. With no grants, rr_ptr is held.
- Port outputs are combinational from the grant:
  - granted port: addrN = granted address; weN = req_we; data_outN = req_wdata.
  - idle port: weN=0, addrN=0, data_outN=0.
- Return pipeline, per port, READ_LAT stages of {valid, req_id, tag, we}.
  - Stage 0 is loaded at the issue edge; the pipeline shifts every cycle with no stall.
  - On exit, resp_valid[req_id] pulses 1 cycle.
  - resp_data = data_inN for reads, 0 for writes. resp_tag = stored tag.
- Both ports may respond in the same cycle. They always target distinct requesters (one-port-per-requester rule), so the two responses never collide.
- Responses are unconditionally accepted; requesters must sink them.
- Issue throughput is 2 accesses/cycle maximum. Response latency is exactly READ_LAT cycles after acceptance.
- Pointer wrap: rr_ptr = NREQ-1 with requester 0 granted last gives rr_ptr = 1.

Decomposition:
- Shared package mem_arb_pkg holds:
  - localparams for requester IDs (REQ_FETCH=0, REQ_LOAD=1, REQ_STORE=2)
  - clog2-based ID width
  - the return-pipeline entry struct {valid, id, tag, we}
- One sub-module is natural: mem_ret_pipe. It is a READ_LAT-deep shift register of entries with async reset, instantiated once per port.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, all req_valid=0 -> we1/2=0, addr1/2=0, resp_valid=0, rr_ptr=0.
- Single read: req0 read addr 0x1234, tag 5, READ_LAT=1, memory returns 0xA5 -> req_ready[0]=1 that cycle, addr1=0x1234, we1=0. Next cycle resp_valid[0]=1, resp_data=0xA5, resp_tag=5.
- Three-way contention, all valid every cycle, NREQ=3:
  - cycle 1 grants {0,1}
  - cycle 2 grants {2,0}
  - cycle 3 grants {1,2}
  - each requester is served 2 of 3 cycles.
- Address hazard: req0 write 0x0040 data 0x11, req1 read 0x0040 same cycle -> only port 1 issues (we1=1), req_ready[1]=0. Next cycle req1 issues and reads back 0x11.
- Simultaneous responses, READ_LAT=2: req1 read 0x10 (mem 0x22) and req2 write 0x20 -> two cycles later resp_valid[1]=1 with 0x22 and resp_valid[2]=1 with data 0, both in the same cycle.
- Reset mid-operation: issue read, assert rst before READ_LAT elapses -> no resp_valid pulse after release, and rr_ptr=0.
